// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between IF, the decode stage and EXE.
// master = decode stage view, slave = surrounding pipeline / testbench view.
interface decode_stage_if #(
  parameter int unsigned OPW = 3,
  parameter int unsigned RAW = 3
);
  localparam int unsigned INST_W = OPW + 3 * RAW;

  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] inst;
  logic              out_valid;
  logic              out_ready;
  logic              registerwrite;
  logic              aluop;
  logic              alusrc;
  logic              memw;
  logic              reg2mem;
  logic              illegal;
  logic [RAW-1:0]    rd;
  logic [RAW-1:0]    rs1;
  logic [RAW-1:0]    rs2;
  logic [RAW-1:0]    imm;

  modport master (
    input  in_valid, inst, out_ready,
    output in_ready, out_valid, registerwrite, aluop, alusrc, memw, reg2mem,
           illegal, rd, rs1, rs2, imm
  );

  modport slave (
    output in_valid, inst, out_ready,
    input  in_ready, out_valid, registerwrite, aluop, alusrc, memw, reg2mem,
           illegal, rd, rs1, rs2, imm
  );
endinterface

// File: rtl/decode_stage.sv
// Registered ID stage: decodes control/fields, flags illegal opcodes, stalls one cycle on load-use.
// Optional DECODE_PERF_CNT_EN adds issue_cnt / stall_cnt performance counters.
module decode_stage #(
  parameter int unsigned OPW     = 3,
  parameter int unsigned RAW     = 3,
  parameter int unsigned OP_ADD  = 0,
  parameter int unsigned OP_ADDI = 4,
  parameter int unsigned OP_SW   = 5,
  parameter int unsigned OP_LW   = 6,
  parameter int unsigned OP_SLL  = 7
`ifdef DECODE_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic           sysclk,
  input  logic           reset,
  decode_stage_if.master io
`ifdef DECODE_PERF_CNT_EN
  , output logic [CNT_W-1:0] issue_cnt
  , output logic [CNT_W-1:0] stall_cnt
`endif
);
  localparam int unsigned INST_W = OPW + 3 * RAW;

  typedef struct packed {
    logic           registerwrite;
    logic           aluop;
    logic           alusrc;
    logic           memw;
    logic           reg2mem;
    logic           illegal;
    logic [RAW-1:0] rd;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] low;
  } dec_t;

  logic [OPW-1:0] in_op;
  dec_t           in_dec;
  logic           in_uses_rs2;
  logic           hazard;
  logic           in_ready_c;
  logic           in_xfer;

  dec_t out_d, out_q;
  logic out_valid_d, out_valid_q;

  // Field extraction and control decode of the incoming instruction.
  always_comb begin
    in_op         = io.inst[3*RAW +: OPW];
    in_dec        = '0;
    in_dec.rd     = io.inst[2*RAW +: RAW];
    in_dec.rs1    = io.inst[RAW +: RAW];
    in_dec.low    = io.inst[0 +: RAW];
    in_uses_rs2   = 1'b0;
    case (in_op)
      OPW'(OP_ADD): begin
        {in_dec.registerwrite, in_dec.aluop, in_dec.alusrc} = 3'b111;
        in_uses_rs2 = 1'b1;
      end
      OPW'(OP_ADDI): begin
        {in_dec.registerwrite, in_dec.aluop} = 2'b11;
      end
      OPW'(OP_SW): begin
        {in_dec.aluop, in_dec.memw} = 2'b11;
        in_uses_rs2 = 1'b1;
      end
      OPW'(OP_LW): begin
        {in_dec.registerwrite, in_dec.aluop, in_dec.reg2mem} = 3'b111;
      end
      OPW'(OP_SLL): begin
        {in_dec.registerwrite, in_dec.alusrc} = 2'b11;
        in_uses_rs2 = 1'b1;
      end
      default: begin
        {in_dec.aluop, in_dec.alusrc, in_dec.illegal} = 3'b111;
      end
    endcase
  end

  // Load-use hazard against the held instruction, handshake, next output register value.
  always_comb begin
    hazard = out_valid_q && out_q.reg2mem && io.in_valid && !in_dec.illegal &&
             ((in_dec.rs1 == out_q.rd) || (in_uses_rs2 && (in_dec.low == out_q.rd)));
    in_ready_c  = (!out_valid_q || io.out_ready) && !hazard;
    in_xfer     = io.in_valid && in_ready_c;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_d       = in_dec;
    end else if (!out_valid_q || io.out_ready) begin
      // Drained with nothing accepted (idle or hazard bubble): empty, cleared slot.
      out_valid_d = 1'b0;
      out_d       = '0;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign io.in_ready      = in_ready_c;
  assign io.out_valid     = out_valid_q;
  assign io.registerwrite = out_q.registerwrite;
  assign io.aluop         = out_q.aluop;
  assign io.alusrc        = out_q.alusrc;
  assign io.memw          = out_q.memw;
  assign io.reg2mem       = out_q.reg2mem;
  assign io.illegal       = out_q.illegal;
  assign io.rd            = out_q.rd;
  assign io.rs1           = out_q.rs1;
  assign io.rs2           = out_q.low;
  assign io.imm           = out_q.low;

`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] issue_cnt_d, issue_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    issue_cnt_d = issue_cnt_q + (in_xfer ? CNT_W'(1) : CNT_W'(0));
    stall_cnt_d = stall_cnt_q + (hazard  ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule
